// File: rtl/regfile_mp_sb_pkg.sv
// Shared defaults and types for the multi-port register file and its scoreboard.
package regfile_pkg;

   localparam int XLEN     = 32;
   localparam int NREGS    = 32;
   localparam int AW       = $clog2(NREGS);
   localparam int ZERO_IDX = 0;

   typedef logic [AW-1:0]   reg_idx_t;
   typedef logic [XLEN-1:0] xword_t;

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Read, write, issue-set and scoreboard signals of the multi-port register file.
interface regfile_mp_sb_if #(
   parameter int XLEN  = regfile_pkg::XLEN,
   parameter int NREGS = regfile_pkg::NREGS,
   parameter int NRD   = 4,
   parameter int NWR   = 2
);
   localparam int AW = $clog2(NREGS);

   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_ready;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic [NWR-1:0]      set_en;
   logic [NWR*AW-1:0]   set_addr;
   logic                flush;
   logic [NREGS-1:0]    busy_vec;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, set_en, set_addr, flush,
      input  rd_data, rd_ready, busy_vec
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, set_en, set_addr, flush,
      output rd_data, rd_ready, busy_vec
   );

endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// Per-register busy bits: set at issue, cleared at writeback, wiped by flush.
module regfile_scoreboard #(
   parameter int  NREGS    = regfile_pkg::NREGS,
   parameter int  NWR      = 2,
   parameter int  ZERO_REG = 1,
   localparam int AW       = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR-1:0]      set_en,
   input  logic [NWR*AW-1:0]   set_addr,
   input  logic                flush,
   output logic [NREGS-1:0]    busy_vec
);
   import regfile_pkg::*;

   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;

   always_comb begin
      busy_nxt = busy;
      if (flush) begin
         busy_nxt = '0;
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (wr_en[j]) busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
         end
         // sets applied after clears: the new producer is younger than the retiring one
         for (int j = 0; j < NWR; j++) begin
            if (set_en[j]) busy_nxt[set_addr[j*AW +: AW]] = 1'b1;
         end
      end
      if (ZERO_REG != 0) busy_nxt[ZERO_IDX] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) busy <= '0;
      else          busy <= busy_nxt;
   end

   assign busy_vec = busy;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port flop-based register file with write-through bypass and busy scoreboard.
module regfile_mp_sb #(
   parameter int XLEN     = regfile_pkg::XLEN,
   parameter int NREGS    = regfile_pkg::NREGS,
   parameter int NRD      = 4,
   parameter int NWR      = 2,
   parameter int ZERO_REG = 1
) (
   input  logic           clk,
   input  logic           reset_n,
   regfile_mp_sb_if.slave bus
);
   import regfile_pkg::*;

   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]  regs   [NREGS];
   logic [NREGS-1:0] reg_we;
   logic [XLEN-1:0]  reg_wd [NREGS];
   logic [NREGS-1:0] busy_vec;

   if (NREGS < 2 || (1 << AW) != NREGS) begin : g_bad_nregs
      $error("regfile_mp_sb: NREGS must be a power of two >= 2");
   end

   function automatic logic is_zero(input logic [AW-1:0] a);
      return (ZERO_REG != 0) && (a == AW'(ZERO_IDX));
   endfunction

   // Ascending scan lets the youngest (highest-index) write port win an address clash.
   always_comb begin
      reg_we = '0;
      for (int i = 0; i < NREGS; i++) reg_wd[i] = '0;
      for (int j = 0; j < NWR; j++) begin
         if (bus.wr_en[j] && !is_zero(bus.wr_addr[j*AW +: AW])) begin
            reg_we[bus.wr_addr[j*AW +: AW]] = 1'b1;
            reg_wd[bus.wr_addr[j*AW +: AW]] = bus.wr_data[j*XLEN +: XLEN];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (reg_we[i]) regs[i] <= reg_wd[i];
         end
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] data;
      logic            hit;

      assign ra = bus.rd_addr[k*AW +: AW];

      always_comb begin
         data = regs[ra];
         hit  = 1'b0;
         for (int j = 0; j < NWR; j++) begin
            if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == ra) begin
               data = bus.wr_data[j*XLEN +: XLEN];
               hit  = 1'b1;
            end
         end
         if (is_zero(ra)) begin
            data = '0;
            hit  = 1'b0;
         end
      end

      assign bus.rd_data[k*XLEN +: XLEN] = data;
      assign bus.rd_ready[k]             = !busy_vec[ra] || hit || is_zero(ra);
   end

   regfile_scoreboard #(
      .NREGS    (NREGS),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_en    (bus.wr_en),
      .wr_addr  (bus.wr_addr),
      .set_en   (bus.set_en),
      .set_addr (bus.set_addr),
      .flush    (bus.flush),
      .busy_vec (busy_vec)
   );

   assign bus.busy_vec = busy_vec;

endmodule
